// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types, default 800x600@60 timing and the region decoder.
package vga_timing_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
    typedef enum logic [1:0] {FP, SYNC, BP, ACTIVE} region_e;

    localparam int unsigned DEF_BIT_DEPTH = 8;
    localparam int unsigned DEF_CHANNELS  = 1;
    localparam int unsigned DEF_H_ACTIVE  = 800;
    localparam int unsigned DEF_H_FP      = 40;
    localparam int unsigned DEF_H_SYNC    = 128;
    localparam int unsigned DEF_H_BP      = 88;
    localparam int unsigned DEF_V_ACTIVE  = 600;
    localparam int unsigned DEF_V_FP      = 1;
    localparam int unsigned DEF_V_SYNC    = 4;
    localparam int unsigned DEF_V_BP      = 23;
    localparam int unsigned DEF_IMG_COLS  = 512;
    localparam int unsigned DEF_IMG_ROWS  = 512;

    // Axis layout is FP, SYNC, BP, then ACTIVE up to the total.
    function automatic region_e region_of(input int unsigned count, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
        if (count < fp)             return FP;
        if (count < fp + sync)      return SYNC;
        if (count < fp + sync + bp) return BP;
        return ACTIVE;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrapping counter for one raster axis; wrap_o flags the increment
// that takes the count from TOTAL-1 back to 0.
module vga_axis_counter #(
    parameter int unsigned TOTAL = 1056,
    parameter int unsigned W     = $clog2(TOTAL)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap_o = inc_i && (cnt_q == LAST);
    assign cnt_o  = cnt_q;

    // Next count: clear dominates, otherwise step and wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)      cnt_d = '0;
        else if (inc_i) cnt_d = wrap_o ? '0 : cnt_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vga_frame_streamer.sv
// VGA raster generator that pulls window pixels over valid/ready and emits
// registered HS/VS/DE/RGB, a frame-start pulse and a sticky underflow flag.
// Optional macro TEST_PATTERN_EN adds pattern_mode_i (horizontal ramp source).
module vga_frame_streamer
    import vga_timing_pkg::*;
#(
    parameter int unsigned BIT_DEPTH = DEF_BIT_DEPTH,
    parameter int unsigned CHANNELS  = DEF_CHANNELS,
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned IMG_COLS  = DEF_IMG_COLS,
    parameter int unsigned IMG_ROWS  = DEF_IMG_ROWS,
    parameter int unsigned IMG_X0    = 0,
    parameter int unsigned IMG_Y0    = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [BIT_DEPTH*CHANNELS-1:0] s_pixel_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    output logic                          hs_o,
    output logic                          vs_o,
    output logic                          de_o,
    output logic [BIT_DEPTH-1:0]          r_o,
    output logic [BIT_DEPTH-1:0]          g_o,
    output logic [BIT_DEPTH-1:0]          b_o,
    output logic                          frame_start_o,
    output logic                          underflow_o,
    input  logic                          underflow_clr_i
`ifdef TEST_PATTERN_EN
    ,
    input  logic                          pattern_mode_i
`endif
);
    localparam int unsigned H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int unsigned V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int unsigned H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned WIN_X0  = H_BLANK + IMG_X0;
    localparam int unsigned WIN_Y0  = V_BLANK + IMG_Y0;

    state_e state_q, state_d;
    logic [HW-1:0] x_q;
    logic [VW-1:0] y_q;
    logic h_wrap, v_wrap, running, in_win, pat_mode;
    logic [BIT_DEPTH-1:0] s_r, s_g, s_b, pat_px;
    logic [HW-1:0] x_off;
    logic hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, uf_q, uf_d;
    logic [BIT_DEPTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    // Counters run only outside IDLE and sit at (0,0) while idle.
    assign running = (state_q != IDLE);

    vga_axis_counter #(.TOTAL(H_TOTAL), .W(HW)) u_hcnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(!running), .inc_i(running),
        .cnt_o(x_q), .wrap_o(h_wrap)
    );
    vga_axis_counter #(.TOTAL(V_TOTAL), .W(VW)) u_vcnt (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(!running), .inc_i(h_wrap),
        .cnt_o(y_q), .wrap_o(v_wrap)
    );

`ifdef TEST_PATTERN_EN
    assign pat_mode = pattern_mode_i;
`else
    assign pat_mode = 1'b0;
`endif

    // Split the incoming pixel into channels; grey is replicated.
    if (CHANNELS == 3) begin : g_rgb
        assign s_r = s_pixel_i[3*BIT_DEPTH-1:2*BIT_DEPTH];
        assign s_g = s_pixel_i[2*BIT_DEPTH-1:BIT_DEPTH];
        assign s_b = s_pixel_i[BIT_DEPTH-1:0];
    end else begin : g_grey
        assign s_r = s_pixel_i[BIT_DEPTH-1:0];
        assign s_g = s_pixel_i[BIT_DEPTH-1:0];
        assign s_b = s_pixel_i[BIT_DEPTH-1:0];
    end

    assign in_win = running
                 && (32'(x_q) >= WIN_X0) && (32'(x_q) < WIN_X0 + IMG_COLS)
                 && (32'(y_q) >= WIN_Y0) && (32'(y_q) < WIN_Y0 + IMG_ROWS);
    assign s_ready_o = in_win && !pat_mode;
    assign x_off     = x_q - HW'(WIN_X0);
    assign pat_px    = BIT_DEPTH'(x_off);

    // Run/drain control: DRAIN finishes the frame unless re-enabled.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_i) state_d = RUN;
            RUN:     if (!en_i) state_d = DRAIN;
            DRAIN:   if (en_i) state_d = RUN;
                     else if (v_wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Output next-state decoded from the current counters; a missing window
    // pixel blanks to zero but keeps de high and latches underflow.
    always_comb begin
        hs_d = !(running && region_of(32'(x_q), H_FP, H_SYNC, H_BP) == SYNC);
        vs_d = !(running && region_of(32'(y_q), V_FP, V_SYNC, V_BP) == SYNC);
        de_d = in_win;
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        if (in_win && pat_mode) begin
            r_d = pat_px; g_d = pat_px; b_d = pat_px;
        end else if (in_win && s_valid_i) begin
            r_d = s_r; g_d = s_g; b_d = s_b;
        end
        fs_d = (state_q == RUN) && (x_q == '0) && (y_q == '0);
        uf_d = uf_q;
        if (in_win && !pat_mode && !s_valid_i) uf_d = 1'b1;
        else if (underflow_clr_i)              uf_d = 1'b0;
    end

    // Registered video outputs, one clock behind the counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_q <= 1'b1; vs_q <= 1'b1; de_q <= 1'b0;
            r_q  <= '0;   g_q  <= '0;   b_q  <= '0;
            fs_q <= 1'b0; uf_q <= 1'b0;
        end else begin
            hs_q <= hs_d; vs_q <= vs_d; de_q <= de_d;
            r_q  <= r_d;  g_q  <= g_d;  b_q  <= b_d;
            fs_q <= fs_d; uf_q <= uf_d;
        end
    end

    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign de_o          = de_q;
    assign r_o           = r_q;
    assign g_o           = g_q;
    assign b_o           = b_q;
    assign frame_start_o = fs_q;
    assign underflow_o   = uf_q;
endmodule
